// File: rtl/reg_pkg.sv
// Shared types and sizing for the physical register file and its ready scoreboard.
// The same-cycle writeback bypass is enabled by defining PRF_WB_BYPASS_EN (see phys_reg_file_sb).
package reg_pkg;

   localparam int WORD_SIZE      = 32;
   localparam int NUM_PHYS_REGS  = 64;
   localparam int IDX_W          = $clog2(NUM_PHYS_REGS);
   localparam int CONFLICT_CNT_W = 8;

   typedef struct packed {
      logic                 en;
      logic [IDX_W-1:0]     index_in;
      logic [WORD_SIZE-1:0] data_in;
   } RegFileWritePort;

   typedef struct packed {
      logic             en;
      logic [IDX_W-1:0] index;
   } RegFileAllocPort;

   // A PR index is "live" unless it names the hardwired zero register.
   function automatic logic index_live(input logic [IDX_W-1:0] idx, input logic zero_reg_en);
      return !(zero_reg_en && (idx == '0));
   endfunction

endpackage

// File: rtl/prf_scoreboard.sv
// Per-register ready bits. Priority for one register in one cycle: flush > alloc > write.
// Ready lookups are combinational, one per read port.
module prf_scoreboard #(
   parameter int NUM_PHYS_REGS   = reg_pkg::NUM_PHYS_REGS,
   parameter int NUM_READ_PORTS  = 4,
   parameter int NUM_WRITE_PORTS = 2,
   parameter int NUM_ALLOC_PORTS = 2,
   parameter int ZERO_REG_EN     = 1
) (
   input  logic                                                clk,
   input  logic                                                rst,
   input  logic                                                flush,
   input  logic [NUM_WRITE_PORTS-1:0]                          wr_en,
   input  logic [NUM_WRITE_PORTS-1:0][$clog2(NUM_PHYS_REGS)-1:0] wr_index,
   input  reg_pkg::RegFileAllocPort [NUM_ALLOC_PORTS-1:0]      alloc_ports,
   input  logic [NUM_READ_PORTS-1:0][$clog2(NUM_PHYS_REGS)-1:0]  rd_index,
   output logic [NUM_READ_PORTS-1:0]                           rd_ready
);
   import reg_pkg::*;

   localparam logic ZERO_EN = (ZERO_REG_EN != 0);

   logic [NUM_PHYS_REGS-1:0] ready_q;
   logic [NUM_PHYS_REGS-1:0] ready_d;

   // Later assignments override earlier ones, so apply writes, then allocs, then flush.
   always_comb begin
      ready_d = ready_q;
      for (int w = 0; w < NUM_WRITE_PORTS; w++) begin
         if (wr_en[w] && index_live(wr_index[w], ZERO_EN)) begin
            ready_d[wr_index[w]] = 1'b1;
         end
      end
      for (int a = 0; a < NUM_ALLOC_PORTS; a++) begin
         if (alloc_ports[a].en && index_live(alloc_ports[a].index, ZERO_EN)) begin
            ready_d[alloc_ports[a].index] = 1'b0;
         end
      end
      if (flush) begin
         ready_d = '1;
      end
      if (ZERO_EN) begin
         ready_d[0] = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ready_q <= '1;
      end else begin
         ready_q <= ready_d;
      end
   end

   always_comb begin
      for (int r = 0; r < NUM_READ_PORTS; r++) begin
         rd_ready[r] = ready_q[rd_index[r]];
      end
   end

endmodule

// File: rtl/phys_reg_file_sb.sv
// Multi-ported physical register file with ready scoreboard and write-conflict tracking.
// Define PRF_WB_BYPASS_EN to forward same-cycle writeback data onto the read ports.
module phys_reg_file_sb #(
   parameter int WORD_SIZE       = reg_pkg::WORD_SIZE,
   parameter int NUM_PHYS_REGS   = reg_pkg::NUM_PHYS_REGS,
   parameter int NUM_READ_PORTS  = 4,
   parameter int NUM_WRITE_PORTS = 2,
   parameter int NUM_ALLOC_PORTS = 2,
   parameter int ZERO_REG_EN     = 1
) (
   input  logic                                                 clk,
   input  logic                                                 rst,
   input  logic [NUM_READ_PORTS-1:0]                            read_en,
   input  logic [NUM_READ_PORTS-1:0][$clog2(NUM_PHYS_REGS)-1:0] read_index,
   output logic [NUM_READ_PORTS-1:0][WORD_SIZE-1:0]             read_data,
   output logic [NUM_READ_PORTS-1:0]                            read_ready,
   input  reg_pkg::RegFileWritePort [NUM_WRITE_PORTS-1:0]       write_ports,
   input  logic [NUM_ALLOC_PORTS-1:0]                           alloc_en,
   input  logic [NUM_ALLOC_PORTS-1:0][$clog2(NUM_PHYS_REGS)-1:0] alloc_index,
   input  logic                                                 flush,
   output logic                                                 conflict_err,
   output logic [reg_pkg::CONFLICT_CNT_W-1:0]                   conflict_cnt
);
   import reg_pkg::*;

   localparam int   IW      = $clog2(NUM_PHYS_REGS);
   localparam logic ZERO_EN = (ZERO_REG_EN != 0);

   logic [WORD_SIZE-1:0]                 regs_q [NUM_PHYS_REGS];
   logic [NUM_WRITE_PORTS-1:0]           wr_live;
   logic [NUM_WRITE_PORTS-1:0][IW-1:0]   wr_index;
   RegFileAllocPort [NUM_ALLOC_PORTS-1:0] alloc_ports;
   logic [NUM_READ_PORTS-1:0]            sb_ready;
   logic                                 conflict;

   // Writes to the zero register are dropped here so they neither update state nor count as conflicts.
   always_comb begin
      for (int w = 0; w < NUM_WRITE_PORTS; w++) begin
         wr_index[w] = write_ports[w].index_in;
         wr_live[w]  = write_ports[w].en && index_live(write_ports[w].index_in, ZERO_EN);
      end
      for (int a = 0; a < NUM_ALLOC_PORTS; a++) begin
         alloc_ports[a].en    = alloc_en[a];
         alloc_ports[a].index = alloc_index[a];
      end
   end

   always_comb begin
      conflict = 1'b0;
      for (int i = 0; i < NUM_WRITE_PORTS; i++) begin
         for (int j = i + 1; j < NUM_WRITE_PORTS; j++) begin
            if (wr_live[i] && wr_live[j] && (wr_index[i] == wr_index[j])) begin
               conflict = 1'b1;
            end
         end
      end
   end

   prf_scoreboard #(
      .NUM_PHYS_REGS   (NUM_PHYS_REGS),
      .NUM_READ_PORTS  (NUM_READ_PORTS),
      .NUM_WRITE_PORTS (NUM_WRITE_PORTS),
      .NUM_ALLOC_PORTS (NUM_ALLOC_PORTS),
      .ZERO_REG_EN     (ZERO_REG_EN)
   ) u_scoreboard (
      .clk         (clk),
      .rst         (rst),
      .flush       (flush),
      .wr_en       (wr_live),
      .wr_index    (wr_index),
      .alloc_ports (alloc_ports),
      .rd_index    (read_index),
      .rd_ready    (sb_ready)
   );

   // Ascending port order means the highest-numbered port's data lands last on a shared index.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_PHYS_REGS; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         for (int w = 0; w < NUM_WRITE_PORTS; w++) begin
            if (wr_live[w]) begin
               regs_q[wr_index[w]] <= write_ports[w].data_in;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         conflict_err <= 1'b0;
         conflict_cnt <= '0;
      end else if (conflict) begin
         conflict_err <= 1'b1;
         if (conflict_cnt != '1) begin
            conflict_cnt <= conflict_cnt + 1'b1;
         end
      end
   end

   always_comb begin
      for (int r = 0; r < NUM_READ_PORTS; r++) begin
         read_data[r]  = '0;
         read_ready[r] = 1'b0;
         if (read_en[r]) begin
            if (ZERO_EN && (read_index[r] == '0)) begin
               read_ready[r] = 1'b1;
            end else begin
               read_data[r]  = regs_q[read_index[r]];
               read_ready[r] = sb_ready[r];
`ifdef PRF_WB_BYPASS_EN
               for (int w = 0; w < NUM_WRITE_PORTS; w++) begin
                  if (wr_live[w] && (wr_index[w] == read_index[r])) begin
                     read_data[r]  = write_ports[w].data_in;
                     read_ready[r] = 1'b1;
                  end
               end
`endif
            end
         end
      end
   end

endmodule

// File: tb/tb_phys_reg_file_sb.sv
// Directed plus randomized bench for phys_reg_file_sb against a per-register reference model.
// Honours PRF_WB_BYPASS_EN when predicting same-cycle reads.
module tb_phys_reg_file_sb;
   import reg_pkg::*;

   localparam int NR  = 4;
   localparam int NW  = 2;
   localparam int NA  = 2;
   localparam int NPR = NUM_PHYS_REGS;

   logic                       clk;
   logic                       rst;
   logic [NR-1:0]              read_en;
   logic [NR-1:0][IDX_W-1:0]   read_index;
   logic [NR-1:0][31:0]        read_data;
   logic [NR-1:0]              read_ready;
   RegFileWritePort [NW-1:0]   write_ports;
   logic [NA-1:0]              alloc_en;
   logic [NA-1:0][IDX_W-1:0]   alloc_index;
   logic                       flush;
   logic                       conflict_err;
   logic [7:0]                 conflict_cnt;

   logic [31:0] mem [NPR];
   logic        rdy [NPR];
   logic        m_err;
   int          m_cnt;
   int          n_checks;
   int          n_fails;

   phys_reg_file_sb dut (
      .clk          (clk),
      .rst          (rst),
      .read_en      (read_en),
      .read_index   (read_index),
      .read_data    (read_data),
      .read_ready   (read_ready),
      .write_ports  (write_ports),
      .alloc_en     (alloc_en),
      .alloc_index  (alloc_index),
      .flush        (flush),
      .conflict_err (conflict_err),
      .conflict_cnt (conflict_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation time limit expired");
      $fatal(1, "[TB] watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NPR; i++) begin
         mem[i] = '0;
         rdy[i] = 1'b1;
      end
      m_err = 1'b0;
      m_cnt = 0;
   endtask

   // Decide each register's fate from the rules: flush beats alloc beats write, last write port wins data.
   task automatic model_update();
      logic [31:0] nmem [NPR];
      logic        nrdy [NPR];
      logic        conf;
      logic        wr;
      logic        al;
      int          hits;
      conf = 1'b0;
      for (int i = 0; i < NPR; i++) begin
         nmem[i] = mem[i];
         wr = 1'b0;
         al = 1'b0;
         hits = 0;
         if (i != 0) begin
            for (int w = 0; w < NW; w++) begin
               if (write_ports[w].en && int'(write_ports[w].index_in) == i) begin
                  nmem[i] = write_ports[w].data_in;
                  wr = 1'b1;
                  hits++;
               end
            end
            for (int a = 0; a < NA; a++) begin
               if (alloc_en[a] && int'(alloc_index[a]) == i) al = 1'b1;
            end
         end
         if (hits > 1) conf = 1'b1;
         nrdy[i] = flush ? 1'b1 : (al ? 1'b0 : (wr ? 1'b1 : rdy[i]));
      end
      for (int i = 0; i < NPR; i++) begin
         mem[i] = nmem[i];
         rdy[i] = nrdy[i];
      end
      if (conf) begin
         m_err = 1'b1;
         if (m_cnt < 255) m_cnt++;
      end
   endtask

   task automatic expected_read(input int r, output logic [31:0] d, output logic rd);
      int idx;
      d = '0;
      rd = 1'b0;
      idx = int'(read_index[r]);
      if (read_en[r]) begin
         if (idx == 0) begin
            rd = 1'b1;
         end else begin
            d = mem[idx];
            rd = rdy[idx];
`ifdef PRF_WB_BYPASS_EN
            for (int w = 0; w < NW; w++) begin
               if (write_ports[w].en && int'(write_ports[w].index_in) == idx) begin
                  d = write_ports[w].data_in;
                  rd = 1'b1;
               end
            end
`endif
         end
      end
   endtask

   task automatic check_output();
      logic [31:0] d;
      logic        rd;
      for (int r = 0; r < NR; r++) begin
         expected_read(r, d, rd);
         check($sformatf("rd%0d_data", r), read_data[r], d);
         check($sformatf("rd%0d_ready", r), {31'b0, read_ready[r]}, {31'b0, rd});
      end
      check("conflict_err", {31'b0, conflict_err}, {31'b0, m_err});
      check("conflict_cnt", {24'b0, conflict_cnt}, 32'(m_cnt));
   endtask

   task automatic clear_inputs();
      read_en = '0;
      read_index = '0;
      alloc_en = '0;
      alloc_index = '0;
      flush = 1'b0;
      for (int w = 0; w < NW; w++) write_ports[w] = '0;
   endtask

   task automatic set_write(input int w, input int idx, input logic [31:0] data);
      write_ports[w].en = 1'b1;
      write_ports[w].index_in = IDX_W'(idx);
      write_ports[w].data_in = data;
   endtask

   task automatic set_read(input int r, input int idx);
      read_en[r] = 1'b1;
      read_index[r] = IDX_W'(idx);
   endtask

   task automatic apply_stimulus();
      read_en = NR'($urandom);
      for (int r = 0; r < NR; r++) read_index[r] = IDX_W'($urandom_range(0, 15));
      for (int w = 0; w < NW; w++) begin
         write_ports[w].en = ($urandom_range(0, 2) != 0);
         write_ports[w].index_in = IDX_W'($urandom_range(0, 15));
         write_ports[w].data_in = $urandom;
      end
      alloc_en = NA'($urandom);
      for (int a = 0; a < NA; a++) alloc_index[a] = IDX_W'($urandom_range(0, 15));
      flush = ($urandom_range(0, 7) == 0);
   endtask

   // Check combinational reads before the edge, clock once, then check state-derived outputs.
   task automatic do_cycle();
      #1;
      check_output();
      @(posedge clk);
      model_update();
      @(negedge clk);
      check_output();
   endtask

   initial begin
      n_checks = 0;
      n_fails = 0;
      clk = 1'b0;
      rst = 1'b1;
      clear_inputs();
      model_reset();
      set_read(0, 0);
      set_read(1, 1);
      set_read(2, 5);
      set_read(3, 31);
      #1;
      check_output();
      for (int r = 0; r < NR; r++) check("reset_ready", {31'b0, read_ready[r]}, 32'd1);
      check("reset_err", {31'b0, conflict_err}, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      $display("[TB] alloc then write");
      clear_inputs();
      alloc_en[0] = 1'b1;
      alloc_index[0] = IDX_W'(7);
      do_cycle();
      clear_inputs();
      set_read(0, 7);
      do_cycle();
      check("alloc_pr7_ready", {31'b0, read_ready[0]}, 32'd0);
      clear_inputs();
      set_write(1, 7, 32'hDEAD);
      do_cycle();
      clear_inputs();
      set_read(0, 7);
      do_cycle();
      check("wr_pr7_data", read_data[0], 32'hDEAD);
      check("wr_pr7_ready", {31'b0, read_ready[0]}, 32'd1);

      $display("[TB] zero register");
      clear_inputs();
      set_write(0, 0, 32'hFF);
      set_write(1, 0, 32'hFF);
      alloc_en[0] = 1'b1;
      do_cycle();
      clear_inputs();
      set_read(2, 0);
      do_cycle();
      check("pr0_data", read_data[2], 32'h0);
      check("pr0_ready", {31'b0, read_ready[2]}, 32'd1);
      check("pr0_no_conflict", {31'b0, conflict_err}, 32'd0);

      $display("[TB] write conflict");
      clear_inputs();
      set_write(0, 9, 32'h11);
      set_write(1, 9, 32'h22);
      do_cycle();
      check("conf_err", {31'b0, conflict_err}, 32'd1);
      check("conf_cnt1", {24'b0, conflict_cnt}, 32'd1);
      set_read(0, 9);
      #1;
      check("conf_pr9_data", read_data[0], 32'h22);
      for (int i = 0; i < 299; i++) do_cycle();
      check("conf_cnt_sat", {24'b0, conflict_cnt}, 32'd255);

      $display("[TB] priority");
      clear_inputs();
      alloc_en[1] = 1'b1;
      alloc_index[1] = IDX_W'(4);
      set_write(0, 4, 32'h55);
      do_cycle();
      clear_inputs();
      set_read(1, 4);
      do_cycle();
      check("prio_pr4_data", read_data[1], 32'h55);
      check("prio_pr4_ready", {31'b0, read_ready[1]}, 32'd0);
      clear_inputs();
      flush = 1'b1;
      alloc_en[0] = 1'b1;
      alloc_index[0] = IDX_W'(4);
      do_cycle();
      clear_inputs();
      set_read(1, 4);
      do_cycle();
      check("flush_pr4_ready", {31'b0, read_ready[1]}, 32'd1);

      $display("[TB] bypass");
      clear_inputs();
      set_write(0, 12, 32'hBEEF);
      set_read(3, 12);
      #1;
`ifdef PRF_WB_BYPASS_EN
      check("bypass_data", read_data[3], 32'hBEEF);
      check("bypass_ready", {31'b0, read_ready[3]}, 32'd1);
`else
      check("nobypass_data", read_data[3], 32'h0);
`endif
      do_cycle();

      $display("[TB] async reset");
      clear_inputs();
      set_read(0, 7);
      set_read(1, 9);
      set_read(2, 4);
      set_read(3, 12);
      #2;
      rst = 1'b1;
      model_reset();
      #1;
      check_output();
      check("arst_pr7_data", read_data[0], 32'h0);
      check("arst_cnt", {24'b0, conflict_cnt}, 32'd0);
      #1;
      rst = 1'b0;
      @(negedge clk);

      $display("[TB] random");
      for (int i = 0; i < 400; i++) begin
         apply_stimulus();
         do_cycle();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

// File: doc/phys_reg_file_sb.md
Name: phys_reg_file_sb

Overview:
Multi-ported physical register file with a per-register ready scoreboard. Sits between rename/issue and writeback in the backend.
- Rename allocates destination PRs, which marks them not-ready.
- Writeback writes data, which marks them ready.
- Issue reads operands and ready bits in the same cycle, with optional same-cycle writeback bypass.
- Adds write-conflict detection and a flush that restores readiness.

Parameters:
- WORD_SIZE, reg_pkg::WORD_SIZE, data width in bits.
- NUM_PHYS_REGS, reg_pkg::NUM_PHYS_REGS, register count; must be a power of two and at least 2.
- NUM_READ_PORTS, 4, operand read ports.
- NUM_WRITE_PORTS, 2, writeback ports.
- NUM_ALLOC_PORTS, 2, rename allocation ports.
- ZERO_REG_EN, 1, when 1, PR0 always reads 0 and ready=1, and writes and allocations to it are ignored.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous active-high reset.
- read_en  in  NUM_READ_PORTS  per-port read enable.
- read_index  in  NUM_READ_PORTS x IDX_W  register index per read port; IDX_W = $clog2(NUM_PHYS_REGS).
- read_data  out  NUM_READ_PORTS x WORD_SIZE  register contents.
- read_ready  out  NUM_READ_PORTS  scoreboard ready bit of the indexed register.
- write_ports  in  NUM_WRITE_PORTS x RegFileWritePort  fields {en, index_in, data_in}.
- alloc_en  in  NUM_ALLOC_PORTS  allocation valid.
- alloc_index  in  NUM_ALLOC_PORTS x IDX_W  PR being allocated.
- flush  in  1  synchronous: set every ready bit to 1.
- conflict_err  out  1  sticky; two enabled write ports targeted the same index in one cycle.
- conflict_cnt  out  8  saturating count of conflict cycles.

Behaviour:
- Reset (async, rst=1):
  - All registers cleared to 0; all ready bits set to 1.
  - conflict_err=0, conflict_cnt=0.
  - read outputs follow the reset state combinationally.
- Reads are combinational, 0-cycle latency.
  - read_en=0 forces read_data='0 and read_ready=0.
  - Otherwise the port returns registers[idx] and ready[idx], subject to bypass (see Optional Feature).
- Writes: every enabled write port updates its register and sets its ready bit to 1 at the clock edge.
- Same-index write conflict:
  - The highest-numbered port wins for both data and ready.
  - conflict_err is set and remains 1 until reset.
  - conflict_cnt increments once per conflicting cycle and saturates at 255.
- Allocation: alloc_en[k] clears ready[alloc_index[k]] at the clock edge; data is untouched.
- Priority for the same register in the same cycle, highest first:
  1. flush
  2. alloc
  3. write
- This means:
  - alloc together with write: the data is written but ready ends at 0.
  - flush together with alloc: ready ends at 1.
  - flush does not block data writes.
- ZERO_REG_EN=1:
  - PR0 writes are dropped, and such writes are excluded from conflict detection.
  - PR0 allocations are dropped.
  - Reads of PR0 return 0 with ready=1.
- Duplicate alloc indices in one cycle are legal and idempotent.
- Reset mid-operation takes effect immediately (async) and overrides all inputs.

Optional Feature:
- Macro PRF_WB_BYPASS_EN.
- Defined:
  - A read whose index matches an enabled write port in the same cycle returns that port's data_in and read_ready=1.
  - If several ports match, the highest-numbered match wins, consistent with write priority.
  - A same-cycle alloc of that index does not affect the bypassed read.
- Undefined: reads return pre-edge state only. Same-cycle writes become visible the next cycle.

Decomposition:
- reg_pkg:
  - RegFileWritePort (already present).
  - New RegFileAllocPort {en, index}; the alloc_* ports may be packed into it.
  - CONFLICT_CNT_W=8.
- One natural sub-module, prf_scoreboard: ready-bit array plus flush/alloc/write priority, exposing ready lookups per read port. The data array and bypass logic stay in the top module.

Test Plan:
- Reset check: assert rst, read ports 0-3 at indices 0,1,5,31 with read_en=1 -> data 0, ready 1 on all ports; conflict_err=0.
- Alloc then write:
  - Cycle 1: alloc PR7 -> next cycle read PR7 gives ready=0.
  - Cycle 3: write PR7=0xDEAD on port 1 -> the following cycle read gives 0xDEAD, ready=1.
- Write conflict: ports 0 and 1 both write PR9 with 0x11 and 0x22 -> PR9=0x22; conflict_err=1; conflict_cnt=1. Repeat 300 cycles -> conflict_cnt=255.
- Priority: same cycle alloc PR4, write PR4=0x55, flush=0 -> PR4 data 0x55, ready 0. Then flush with alloc PR4 -> ready 1.
- Bypass: write PR12=0xBEEF and read PR12 in the same cycle.
  - With PRF_WB_BYPASS_EN -> read_data=0xBEEF, ready=1.
  - Without -> the old value is returned.
- Zero register and async reset:
  - ZERO_REG_EN=1, write PR0=0xFF and alloc PR0 -> reads return 0, ready=1, no conflict flagged.
  - Pulse rst between clock edges -> state clears immediately.
